// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring integer divider for RV32M/RV64M (DIV, DIVU, REM, REMU).
// Runs on operand magnitudes, one quotient bit per cycle, then a sign fix-up step.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the
// iteration phase and finish two cycles after accept.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sel_rem_q, sel_rem_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div_zero_q, div_zero_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;

  logic             dvd_neg, dvs_neg, dvs_zero;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;
`ifdef DIV_EARLY_OUT_EN
  logic             ovf;
`endif

  // Operand decode at accept: signs only matter for signed ops (op_i[0] == 0).
  always_comb begin
    dvd_neg  = ~op_i[0] & dividend_i[WIDTH-1];
    dvs_neg  = ~op_i[0] & divisor_i[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    dvd_mag  = dvd_neg ? (~dividend_i + WIDTH'(1)) : dividend_i;
    dvs_mag  = dvs_neg ? (~divisor_i + WIDTH'(1)) : divisor_i;
    dvs_zero = (divisor_i == '0);
`ifdef DIV_EARLY_OUT_EN
    ovf      = ~op_i[0] & (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor_i);
`endif
  end

  // Datapath helpers for one restoring step and the final sign correction.
  always_comb begin
    rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    trial     = {rem_q[WIDTH-1], rem_shift} - {1'b0, dvs_q};
    // Divide-by-zero keeps the all-ones quotient; its remainder equals |dividend|, so the
    // ordinary remainder negation already reproduces the original dividend.
    quo_fix   = div_zero_q ? '1 : (quo_neg_q ? (~quo_q + WIDTH'(1)) : quo_q);
    rem_fix   = rem_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end

  // Next-state and output logic; flush overrides everything outside IDLE.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    sel_rem_d  = sel_rem_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    tag_d      = tag_q;
    result_d   = result_q;
    tag_out_d  = tag_out_q;
    done_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          rem_d      = '0;
          quo_d      = dvd_mag;
          dvs_d      = dvs_mag;
          cnt_d      = '0;
          sel_rem_d  = op_i[1];
          quo_neg_d  = dvd_neg ^ dvs_neg;
          rem_neg_d  = dvd_neg;
          div_zero_d = dvs_zero;
          tag_d      = tag_i;
          state_d    = StCalc;
`ifdef DIV_EARLY_OUT_EN
          // Preload the magnitudes the iterations would have produced and go to FIX.
          if (dvs_zero || ovf) begin
            rem_d   = dvs_zero ? dvd_mag : '0;
            quo_d   = dvs_zero ? '1 : dvd_mag;
            state_d = StFix;
          end
`endif
        end
      end
      StCalc: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        result_d  = sel_rem_q ? rem_fix : quo_fix;
        tag_out_d = tag_q;
        state_d   = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush_i && (state_q != StIdle)) begin
      state_d   = StIdle;
      done_o    = 1'b0;
      result_d  = result_q;
      tag_out_d = tag_out_q;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign result_o = result_q;
  assign tag_o    = tag_out_q;

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      sel_rem_q  <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      tag_q      <= '0;
      result_q   <= '0;
      tag_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      sel_rem_q  <= sel_rem_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      tag_q      <= tag_d;
      result_q   <= result_d;
      tag_out_q  <= tag_out_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a 32-bit instance for directed and random ops and an
// 8-bit instance for a randomized sweep plus corner operands, both against an arithmetic model.
module tb_div_unit;

  localparam int unsigned W32 = 32;
  localparam int unsigned W8  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        s_start = 1'b0, s_flush = 1'b0;
  logic [1:0]  s_op = '0;
  logic [31:0] s_a = '0, s_b = '0;
  logic [4:0]  s_tag = '0;
  logic        busy32, done32;
  logic [31:0] res32;
  logic [4:0]  tago32;

  logic        t_start = 1'b0, t_flush = 1'b0;
  logic [1:0]  t_op = '0;
  logic [7:0]  t_a = '0, t_b = '0;
  logic [4:0]  t_tag = '0;
  logic        busy8, done8;
  logic [7:0]  res8;
  logic [4:0]  tago8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(s_start), .op_i(s_op), .dividend_i(s_a),
    .divisor_i(s_b), .tag_i(s_tag), .flush_i(s_flush), .busy_o(busy32), .done_o(done32),
    .result_o(res32), .tag_o(tago32)
  );

  div_unit #(.WIDTH(W8), .TAG_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(t_start), .op_i(t_op), .dividend_i(t_a),
    .divisor_i(t_b), .tag_i(t_tag), .flush_i(t_flush), .busy_o(busy8), .done_o(done8),
    .result_o(res8), .tag_o(tago8)
  );

  // RISC-V divide semantics computed with 64-bit arithmetic, then truncated to w bits.
  function automatic logic [31:0] ref_div(int unsigned w, logic [1:0] op, logic [31:0] a,
                                          logic [31:0] b);
    longint unsigned m, ua, ub;
    longint sa, sb, r;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = (ua >= (longint'(1) << (w - 1))) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = (ub >= (longint'(1) << (w - 1))) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    if (ub == 0) r = op[1] ? longint'(ua) : -1;
    else if (!op[0]) r = op[1] ? (sa % sb) : (sa / sb);
    else r = op[1] ? longint'(ua % ub) : longint'(ua / ub);
    return 32'(longint'(r) & m);
  endfunction

  function automatic int exp_lat(int unsigned w, logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint unsigned m;
    bit special;
    m = (longint'(1) << w) - 1;
    special = ((longint'(b) & m) == 0) ||
              (!op[0] && ((longint'(a) & m) == (longint'(1) << (w - 1))) &&
               ((longint'(b) & m) == m));
`ifdef DIV_EARLY_OUT_EN
    if (special) return 2;
`endif
    if (special) return int'(w) + 2;
    return int'(w) + 2;
  endfunction

  // Issue one op on the 32-bit DUT; lat counts cycles from the accept edge to the done cycle.
  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [31:0] res, output logic [4:0] tg,
                       output int lat, output bit tmo);
    int guard;
    tmo = 1'b0;
    lat = 0;
    guard = 0;
    @(negedge clk);
    while (busy32 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    s_start = 1'b1; s_op = op; s_a = a; s_b = b; s_tag = tag;
    @(posedge clk);
    #1;
    s_start = 1'b0; s_op = 2'($urandom); s_a = $urandom; s_b = $urandom; s_tag = 5'($urandom);
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done32) break;
    end
    if (!done32) tmo = 1'b1;
    res = res32;
    tg  = tago32;
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [4:0] tag, output logic [7:0] res, output logic [4:0] tg,
                      output int lat, output bit tmo);
    int guard;
    tmo = 1'b0;
    lat = 0;
    guard = 0;
    @(negedge clk);
    while (busy8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    t_start = 1'b1; t_op = op; t_a = a; t_b = b; t_tag = tag;
    @(posedge clk);
    #1;
    t_start = 1'b0; t_op = 2'($urandom); t_a = 8'($urandom); t_b = 8'($urandom);
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (done8) break;
    end
    if (!done8) tmo = 1'b1;
    res = res8;
    tg  = tago8;
  endtask

  // Directed 32-bit op with result, tag and latency checks.
  task automatic check32(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp_res);
    logic [31:0] res;
    logic [4:0] tg;
    int lat, el;
    bit tmo;
    run32(op, a, b, tag, res, tg, lat, tmo);
    el = exp_lat(W32, op, a, b);
    checks++;
    if (tmo) begin
      failures++;
      $display("FAIL %s timeout: done_o never seen within %0d cycles", name, lat);
    end
    checks++;
    if (res !== exp_res) begin
      failures++;
      $display("FAIL %s result: got %h expected %h", name, res, exp_res);
    end
    checks++;
    if (tg !== tag) begin
      failures++;
      $display("FAIL %s tag: got %0d expected %0d", name, tg, tag);
    end
    checks++;
    if (lat != el) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, el);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy32, done32, res32, tago32} !== '0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h tag=%0d expected all zero",
               busy32, done32, res32, tago32);
    end
    checks++;
    if ({busy8, done8, res8, tago8} !== '0) begin
      failures++;
      $display("FAIL reset_state8: got busy=%b done=%b res=%h tag=%0d expected all zero",
               busy8, done8, res8, tago8);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_signed();
    check32("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
    checks++;
    @(negedge clk);
    if (done32 !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: got done_o=%b one cycle later expected 0", done32);
    end
    check32("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    check32("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD);
    check32("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1);
  endtask

  task automatic test_unsigned();
    check32("divu_max_16", 2'b01, 32'hFFFF_FFFF, 32'h10, 5'd1, 32'h0FFF_FFFF);
    check32("remu_max_16", 2'b11, 32'hFFFF_FFFF, 32'h10, 5'd2, 32'hF);
  endtask

  task automatic test_div_zero();
    check32("div_123_0", 2'b00, 32'd123, 32'd0, 5'd10, 32'hFFFF_FFFF);
    check32("remu_123_0", 2'b11, 32'd123, 32'd0, 5'd11, 32'd123);
    check32("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB);
    check32("divu_9_0", 2'b01, 32'd9, 32'd0, 5'd13, 32'hFFFF_FFFF);
  endtask

  task automatic test_overflow();
    check32("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000);
    check32("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0);
    check32("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0);
  endtask

  task automatic test_random32();
    logic [31:0] a, b;
    logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      op = 2'($urandom);
      check32("rand32", op, a, b, 5'($urandom), ref_div(W32, op, a, b));
    end
  endtask

  // Second start held high while busy must be ignored until the block returns to IDLE.
  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    s_start = 1'b1; s_op = 2'b01; s_a = 32'd1000; s_b = 32'd7; s_tag = 5'd3;
    @(posedge clk);
    #1;
    s_op = 2'b00; s_a = 32'hFFFF_FC18; s_b = 32'd7; s_tag = 5'd9;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done32) break;
    end
    checks++;
    if (lat != int'(W32) + 2 || res32 !== 32'd142 || tago32 !== 5'd3) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d res=%h tag=%0d expected lat=%0d res=%h tag=3",
               lat, res32, tago32, W32 + 2, 32'd142);
    end
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done32) break;
    end
    s_start = 1'b0;
    checks++;
    if (lat != int'(W32) + 3 || res32 !== ref_div(W32, 2'b00, 32'hFFFF_FC18, 32'd7) ||
        tago32 !== 5'd9) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d res=%h tag=%0d expected lat=%0d res=%h tag=9",
               lat, res32, tago32, W32 + 3, ref_div(W32, 2'b00, 32'hFFFF_FC18, 32'd7));
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int seen;
    check32("pre_flush", 2'b01, 32'd77, 32'd5, 5'd4, 32'd15);
    prev = 32'd15;
    @(negedge clk);
    s_start = 1'b1; s_op = 2'b00; s_a = 32'd1234; s_b = 32'd3; s_tag = 5'd20;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    s_flush = 1'b1;
    @(posedge clk);
    #1;
    s_flush = 1'b0;
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== prev) begin
      failures++;
      $display("FAIL flush_calc: got busy=%b done=%b res=%h expected busy=0 done=0 res=%h",
               busy32, done32, res32, prev);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) seen++;
    end
    checks++;
    if (seen != 0 || res32 !== prev || tago32 !== 5'd4) begin
      failures++;
      $display("FAIL flush_quiet: got dones=%0d res=%h tag=%0d expected 0 dones res=%h tag=4",
               seen, res32, tago32, prev);
    end
    check32("post_flush", 2'b00, 32'd1234, 32'd3, 5'd21, 32'd411);
    // Flush together with start in IDLE drops the request.
    @(negedge clk);
    s_start = 1'b1; s_flush = 1'b1; s_op = 2'b01; s_a = 32'd50; s_b = 32'd5;
    @(posedge clk);
    #1;
    s_start = 1'b0; s_flush = 1'b0;
    checks++;
    if (busy32 !== 1'b0) begin
      failures++;
      $display("FAIL flush_start_idle: got busy=%b expected 0", busy32);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    s_start = 1'b1; s_op = 2'b01; s_a = 32'd999; s_b = 32'd4; s_tag = 5'd2;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy32, done32, res32, tago32} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b done=%b res=%h tag=%0d expected all zero",
               busy32, done32, res32, tago32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check32("after_reset", 2'b11, 32'd999, 32'd4, 5'd2, 32'd3);
  endtask

  // 8-bit sweep: all corner pairs and ops, then random pairs.
  task automatic test_sweep8();
    logic [7:0] corners [6];
    logic [7:0] a, b, res;
    logic [1:0] op;
    logic [4:0] tag, tg;
    logic [7:0] expv;
    int lat, el, bad, n;
    bit tmo;
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFE};
    bad = 0;
    n = 0;
    for (int k = 0; k < 144 + 1200; k++) begin
      if (k < 144) begin
        a  = corners[k / 24];
        b  = corners[(k / 4) % 6];
        op = 2'(k % 4);
      end else begin
        a  = 8'($urandom);
        b  = 8'($urandom);
        op = 2'($urandom);
      end
      tag  = 5'($urandom);
      run8(op, a, b, tag, res, tg, lat, tmo);
      expv = 8'(ref_div(W8, op, {24'd0, a}, {24'd0, b}));
      el   = exp_lat(W8, op, {24'd0, a}, {24'd0, b});
      n++;
      checks++;
      if (tmo || res !== expv || tg !== tag || lat != el) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL sweep8 op=%0d a=%h b=%h: got res=%h tag=%0d lat=%0d tmo=%0b expected res=%h tag=%0d lat=%0d",
                   op, a, b, res, tg, lat, tmo, expv, tag, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_random32();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_sweep8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
